// File: rtl/snd_mixer_pkg.sv
// snd_mixer_pkg -- shared types and helpers for the snd_mixer channel mixer.
//   state_t    : mixing-pass FSM states (IDLE, MAC, FIN)
//   GAIN_UNITY : unity gain in unsigned Q3.5 (0x20)
//   clog2      : ceil(log2(value)), 0 for value <= 1
//   sat_s      : clamp a 64-bit signed value to a w-bit signed range
package snd_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [7:0] GAIN_UNITY = 8'h20;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/snd_mixer_dcblock.sv
// snd_mixer_dcblock -- first-order DC-blocking high-pass for the mixer output.
//   y = din - (d >>> DC_SHIFT), saturated to OUT_W signed
//   d += din - (d >>> DC_SHIFT), only on cycles where enable is high
// Ports:
//   clk_49m in  : clock, rising edge
//   reset   in  : synchronous, active-high; clears the filter state
//   enable  in  : advance the filter state this cycle
//   din     in  : OUT_W signed input sample
//   dout    out : OUT_W signed filtered sample (combinational from din and state)
//   clip    out : dout was saturated
module snd_mixer_dcblock
  import snd_mixer_pkg::*;
#(
  parameter int OUT_W    = 16,
  parameter int DC_SHIFT = 8
) (
  input  logic                    clk_49m,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [OUT_W-1:0] din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam int D_W = OUT_W + DC_SHIFT + 1;

  logic signed [D_W-1:0] d_reg;
  logic signed [D_W-1:0] diff_next;
  logic signed [63:0]    y_wide;

  always_comb begin
    diff_next = D_W'(din) - (d_reg >>> DC_SHIFT);
    y_wide    = sat_s(64'(diff_next), OUT_W);
    dout      = OUT_W'(y_wide);
    clip      = (y_wide != 64'(diff_next));
  end

  // The state integrates the unsaturated difference so the filter stays linear.
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      d_reg <= '0;
    end else if (enable) begin
      d_reg <= d_reg + diff_next;
    end
  end

endmodule

// File: rtl/snd_mixer.sv
// snd_mixer -- time-multiplexed PSG channel mixer with per-channel gain/mute.
// One shared multiplier walks the channels one per clock; the sum is shifted,
// saturated, optionally DC-blocked and optionally inverted, giving one signed
// sample per sample_cen strobe (result CHANNELS+2 clocks after the strobe).
// Build option: define SND_MIXER_DCBLOCK_EN to include the DC blocker.
// Ports:
//   clk_49m, reset         : clock and synchronous active-high reset
//   sample_cen             : starts a pass; snapshots ch_in, mute, invert
//   ch_in, mute, invert    : channel samples (unsigned), mutes, output negate
//   gain_wr/addr/data      : gain register write port (Q3.5, unity 0x20)
//   sound, sample_valid    : signed output sample and its update pulse
//   busy, clip, overrun    : pass active, saturation in pass, rejected strobe
module snd_mixer
  import snd_mixer_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int IN_W     = 8,
  parameter int GAIN_W   = 8,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 1,
  parameter int DC_SHIFT = 8
) (
  input  logic                     clk_49m,
  input  logic                     reset,
  input  logic                     sample_cen,
  input  logic [CHANNELS*IN_W-1:0] ch_in,
  input  logic [CHANNELS-1:0]      mute,
  input  logic                     invert,
  input  logic                     gain_wr,
  input  logic [3:0]               gain_addr,
  input  logic [GAIN_W-1:0]        gain_data,
  output logic [OUT_W-1:0]         sound,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     clip,
  output logic                     overrun
);

  localparam int IDX_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam int ACC_W = IN_W + GAIN_W + clog2(CHANNELS);

  state_t                   state_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [ACC_W-1:0]         acc_reg;
  logic [CHANNELS*IN_W-1:0] ch_reg;
  logic [CHANNELS-1:0]      mute_reg;
  logic                     invert_reg;
  logic [GAIN_W-1:0]        gain_reg [CHANNELS];
  logic [OUT_W-1:0]         sound_reg;
  logic                     valid_reg, busy_reg, clip_reg, overrun_reg;

  logic [IN_W-1:0]          ch_sel;
  logic [GAIN_W-1:0]        gain_sel;
  logic [IN_W+GAIN_W-1:0]   prod_next;
  logic signed [63:0]       pre_s, pre_sat, y_in, y_inv, y_fin;
  logic signed [OUT_W-1:0]  y_dc;
  logic                     dc_clip;
  logic                     clip_next;

  // Gain registers; a write and a MAC read of the same channel in one cycle
  // lets the MAC see the old value because the read is combinational.
  always_ff @(posedge clk_49m) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        gain_reg[i] <= GAIN_W'(GAIN_UNITY);
      end else if (gain_wr && gain_addr == 4'(i)) begin
        gain_reg[i] <= gain_data;
      end
    end
  end

  always_comb begin
    ch_sel    = ch_reg[idx_reg*IN_W +: IN_W];
    gain_sel  = gain_reg[idx_reg];
    prod_next = mute_reg[idx_reg] ? '0 : ch_sel * gain_sel;
    pre_s     = $signed(64'(acc_reg >> SHIFT));
    pre_sat   = sat_s(pre_s, OUT_W);
  end

`ifdef SND_MIXER_DCBLOCK_EN
  snd_mixer_dcblock #(
    .OUT_W    (OUT_W),
    .DC_SHIFT (DC_SHIFT)
  ) u_dcblock (
    .clk_49m (clk_49m),
    .reset   (reset),
    .enable  (state_reg == FIN),
    .din     (OUT_W'(pre_sat)),
    .dout    (y_dc),
    .clip    (dc_clip)
  );
`else
  assign y_dc    = OUT_W'(pre_sat);
  assign dc_clip = 1'b0;
`endif

  // Negating the most negative value would wrap, so it is clamped.
  always_comb begin
    y_in      = 64'(y_dc);
    y_inv     = invert_reg ? -y_in : y_in;
    y_fin     = sat_s(y_inv, OUT_W);
    clip_next = (pre_sat != pre_s) | dc_clip | (y_fin != y_inv);
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      acc_reg     <= '0;
      ch_reg      <= '0;
      mute_reg    <= '0;
      invert_reg  <= 1'b0;
      sound_reg   <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      clip_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sample_cen) begin
            ch_reg     <= ch_in;
            mute_reg   <= mute;
            invert_reg <= invert;
            acc_reg    <= '0;
            idx_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= MAC;
          end
        end
        MAC: begin
          overrun_reg <= sample_cen;
          acc_reg     <= acc_reg + ACC_W'(prod_next);
          if (idx_reg == IDX_W'(CHANNELS - 1)) begin
            state_reg <= FIN;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        FIN: begin
          overrun_reg <= sample_cen;
          sound_reg   <= OUT_W'(y_fin);
          valid_reg   <= 1'b1;
          clip_reg    <= clip_next;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sound        = sound_reg;
  assign sample_valid = valid_reg;
  assign busy         = busy_reg;
  assign clip         = clip_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_snd_mixer.sv
// tb_snd_mixer -- scoreboard bench for snd_mixer at default parameters.
// Expected samples are queued when a strobe is driven and compared, together
// with the strobe-to-sample latency, when sample_valid appears.
// Build option: with SND_MIXER_DCBLOCK_EN defined the DC-blocker sequence runs.
module tb_snd_mixer;

  localparam int CH   = 6;
  localparam int IN_W = 8;
  localparam int GW   = 8;
  localparam int OW   = 16;

  logic               clk_49m = 1'b0;
  logic               reset = 1'b1;
  logic               sample_cen = 1'b0;
  logic [CH*IN_W-1:0] ch_in = '0;
  logic [CH-1:0]      mute = '0;
  logic               invert = 1'b0;
  logic               gain_wr = 1'b0;
  logic [3:0]         gain_addr = '0;
  logic [GW-1:0]      gain_data = '0;
  logic [OW-1:0]      sound;
  logic               sample_valid, busy, clip, overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sb_en = 1'b1;
  int exp_sound_q[$];
  bit exp_clip_q[$];
  int exp_cyc_q[$];
  int gain_m[CH];

  snd_mixer dut (
    .clk_49m      (clk_49m),
    .reset        (reset),
    .sample_cen   (sample_cen),
    .ch_in        (ch_in),
    .mute         (mute),
    .invert       (invert),
    .gain_wr      (gain_wr),
    .gain_addr    (gain_addr),
    .gain_data    (gain_data),
    .sound        (sound),
    .sample_valid (sample_valid),
    .busy         (busy),
    .clip         (clip),
    .overrun      (overrun)
  );

  always #5 clk_49m = ~clk_49m;
  always @(posedge clk_49m) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_49m);
    #1;
  endtask

  task automatic push_exp(input int s, input bit c);
    exp_sound_q.push_back(s);
    exp_clip_q.push_back(c);
    exp_cyc_q.push_back(cyc);
  endtask

  // Reference mixer: gain-weighted sum of unmuted channels, >>1, clamp, negate.
  task automatic push_model();
    longint acc;
    longint pre;
    bit     c;
    acc = 0;
    for (int i = 0; i < CH; i++) begin
      if (!mute[i]) acc += longint'(ch_in[i*IN_W +: IN_W]) * gain_m[i];
    end
    pre = acc >>> 1;
    c   = 1'b0;
    if (pre > 32767) begin
      pre = 32767;
      c   = 1'b1;
    end
    push_exp(invert ? int'(-pre) : int'(pre), c);
  endtask

  task automatic strobe();
    sample_cen = 1'b1;
    tick(1);
    sample_cen = 1'b0;
  endtask

  task automatic write_gain(input int addr, input int data);
    gain_wr   = 1'b1;
    gain_addr = 4'(addr);
    gain_data = GW'(data);
    if (addr < CH) gain_m[addr] = data;
    tick(1);
    gain_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk_49m);
      k++;
    end
    if (busy) check_val("idle_timeout", 1, 0);
    tick(1);
  endtask

  // Scoreboard side: one line per produced sample.
  always @(negedge clk_49m) begin
    if (!reset && sample_valid && sb_en) begin
      if (exp_sound_q.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        int s, sc;
        bit c;
        s  = exp_sound_q.pop_front();
        c  = exp_clip_q.pop_front();
        sc = exp_cyc_q.pop_front();
        $display("sample cyc=%0d sound=%0d clip=%0b exp_sound=%0d exp_clip=%0b",
                 cyc, $signed(sound), clip, s, c);
        check_val("sound", longint'($signed(sound)), s);
        check_val("clip", clip, c);
        check_val("latency", cyc - sc, 8);
      end
    end
  end

  initial begin
    for (int i = 0; i < CH; i++) gain_m[i] = 32;
    tick(3);
    @(negedge clk_49m);
    check_val("rst_sound", sound, 0);
    check_val("rst_valid", sample_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_clip", clip, 0);
    check_val("rst_overrun", overrun, 0);
    tick(1);
    reset = 1'b0;
    tick(1);

`ifdef SND_MIXER_DCBLOCK_EN
    begin
      int prev;
      ch_in = '0;
      ch_in[IN_W-1:0] = 8'hFF;
      push_exp(4080, 1'b0);
      strobe();
      wait_idle();
      push_exp(4065, 1'b0);
      strobe();
      wait_idle();
      sb_en = 1'b0;
      prev = 4065;
      for (int p = 2; p < 2048; p++) begin
        strobe();
        wait_idle();
        if ($signed(sound) > prev) check_val("dc_monotonic", $signed(sound), prev);
        prev = $signed(sound);
      end
      check_val("dc_settled", ($signed(sound) < 64 && $signed(sound) > -64) ? 1 : 0, 1);
    end
`else
    // All channels full scale at unity gain.
    ch_in = {CH{8'hFF}};
    push_exp(24480, 1'b0);
    strobe();
    @(negedge clk_49m);
    check_val("busy_after_cen", busy, 1);
    wait_idle();

    // Channel 0 alone, the rest muted with non-zero data, inverted.
    ch_in = {$urandom, $urandom};
    ch_in[IN_W-1:0] = 8'hFF;
    mute = 6'b111110;
    invert = 1'b1;
    push_exp(-4080, 1'b0);
    strobe();
    wait_idle();

    // Overrun: second strobe 3 clocks in is rejected, one at +8 is accepted.
    ch_in = {CH{8'hFF}};
    mute = '0;
    invert = 1'b0;
    push_exp(24480, 1'b0);
    strobe();
    tick(2);
    sample_cen = 1'b1;
    @(negedge clk_49m);
    check_val("overrun_early", overrun, 0);
    tick(1);
    sample_cen = 1'b0;
    @(negedge clk_49m);
    check_val("overrun_pulse", overrun, 1);
    tick(1);
    @(negedge clk_49m);
    check_val("overrun_len", overrun, 0);
    tick(3);
    push_exp(24480, 1'b0);
    strobe();
    wait_idle();

    // Full gain saturates, with and without invert.
    for (int i = 0; i < CH; i++) write_gain(i, 255);
    push_exp(32767, 1'b1);
    strobe();
    wait_idle();
    invert = 1'b1;
    push_exp(-32767, 1'b1);
    strobe();
    wait_idle();

    // Reset mid-pass: no sample, outputs and gains return to reset values.
    invert = 1'b0;
    strobe();
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk_49m);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_sound", sound, 0);
    tick(12);
    for (int i = 0; i < CH; i++) gain_m[i] = 32;
    push_exp(24480, 1'b0);
    strobe();
    wait_idle();

    // Out-of-range writes ignored; in-pass writes: same-cycle read sees old
    // gain for channel 0, channel 5 (not yet processed) sees the new one.
    write_gain(6, 0);
    write_gain(15, 0);
    push_exp(20400, 1'b0);
    strobe();
    write_gain(0, 0);
    write_gain(5, 0);
    wait_idle();
    push_exp(16320, 1'b0);
    strobe();
    wait_idle();

    // Random gains, inputs, mutes; inputs change right after the strobe.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < CH; i++) write_gain(i, int'($urandom_range(0, 255)));
      ch_in  = {$urandom, $urandom};
      mute   = CH'($urandom);
      invert = 1'($urandom);
      push_model();
      strobe();
      ch_in  = {$urandom, $urandom};
      mute   = ~mute;
      invert = ~invert;
      wait_idle();
    end
`endif

    tick(4);
    check_val("sb_empty", exp_sound_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
